uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
UART receiver for the board RXD line (pin H18, 25 MHz domain), 8N1, LSB first.
- Synchronises RXD, detects and validates the start bit, samples each bit at mid-bit, checks the stop bit.
- Received bytes go into a small first-word-fall-through FIFO with a valid/ready output.
- Downstream command logic (flash-diag control, panel loaders) consumes bytes at its own pace.
- Framing and overrun events are reported as single-cycle pulses.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD with integer truncation (217 at defaults); must be >= 4.
- FIFO_DEPTH, 4, byte entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  raw asynchronous serial line, idle high.
- rx_data  out  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- frame_err  out  1  1-cycle pulse: stop bit sampled low.
- overrun  out  1  1-cycle pulse: good byte dropped because FIFO full.
- busy  out  1  receiver FSM not in IDLE.

Behaviour:

Reset and clocking:
- One clock (clk). Reset is asynchronous and active-high (rst); all flops clear on rst=1 regardless of clk.
- Reset values:
  - rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops=1. FIFO pointers/count=0. FSM=IDLE. Bit counter and baud counter=0.
- Reset mid-frame or with a non-empty FIFO: the partial byte and all FIFO contents are discarded.

Input synchroniser:
- 2-flop synchroniser on rxd. The FSM uses only the synchronised value rs (2 cycles of input latency).

FSM states:
- IDLE: if rs=0, go to START with baud counter=0.
- START: count to CLKS_PER_BIT/2 - 1 (107 at defaults), then sample rs.
  - rs=1: glitch; return to IDLE with no flags.
  - rs=0: baud counter=0, bit index=0, go to DATA.
- DATA: every CLKS_PER_BIT cycles, sample rs into shift register bit [index], LSB first. After bit 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rs.
  - rs=1: push the byte, go to IDLE immediately (at the stop-bit midpoint, so back-to-back frames are received).
  - rs=0: frame_err=1 for one cycle, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: remain until rs=1, then go to IDLE. A break or stuck-low line produces exactly one frame_err.
- busy=1 in START, DATA, STOP, and WAIT_IDLE.

FIFO (first-word fall-through):
- Push occurs in the cycle after the stop sample. rx_valid rises in the cycle after the push, so total latency from the stop-bit midpoint is 2 cycles.
- Pop when rx_valid & rx_ready; the head advances on that clock edge. rx_data holds steady while rx_valid=1 and rx_ready=0.
- Push when full with no simultaneous pop: byte dropped, overrun=1 for one cycle, FIFO unchanged.
- Push when full with a simultaneous pop: both occur, no overrun, count unchanged.
- Push when empty: rx_valid goes 0->1; no bypass, the byte is visible the next cycle.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- rx_ready while empty is ignored.

Test Plan:
1. After reset, send 0xA5 at 115200 (217 clk/bit) with rx_ready=1 -> rx_valid high 1 cycle, rx_data=0xA5; frame_err=0, overrun=0; busy low after the stop midpoint.
2. Send 0x00, 0xFF, 0x3C back-to-back with no idle gap, rx_ready=0 -> after the third frame rx_valid=1 and the FIFO holds 3; pulse rx_ready 3 times -> 0x00, 0xFF, 0x3C in order, then rx_valid=0.
3. rx_ready=0, send 5 bytes 0x01..0x05 -> 4 stored, one overrun pulse on the 5th; drain yields 0x01..0x04. Repeat with rx_ready=1 on the 5th push cycle -> no overrun.
4. Drive rxd low for 50 clks, then high -> returns to IDLE, no byte, no flags. Next, send a frame with stop bit 0 -> one frame_err pulse, no byte; busy held until rxd returns high.
5. Hold rxd low for 20 bit times -> exactly one frame_err, busy=1 throughout; release -> IDLE; the next valid 0x5A is received correctly.
6. Assert rst mid-DATA with 2 bytes queued -> all outputs return to reset values immediately (asynchronously); after release, 0x81 is received correctly and the old bytes are gone.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small first-word-fall-through byte FIFO.
// RXD is double-flopped, the start bit is re-checked at its midpoint, each
// data bit is sampled mid-bit LSB first, and the stop bit gates the push.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Clocks per bit truncates; CLKS_PER_BIT must be >= 4, FIFO_DEPTH a power of two >= 2.
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W      = PTR_W + 1;

    localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   BAUD_HALF = CNT_W'(HALF_BIT);
    localparam logic [COUNT_W-1:0] FIFO_FULL = COUNT_W'(FIFO_DEPTH);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitIdle = 3'd4;

    // Synchroniser
    logic sync1_q, sync2_q;
    logic rs;

    // Receiver FSM
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             frame_err_q, frame_err_d;

    // FIFO
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               pop, full, wr_en;

    assign rs = sync2_q;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // Receiver next-state: start validation, mid-bit sampling, stop check.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rs) begin
                    state_d = StStart;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (baud_q == BAUD_HALF) begin
                    if (rs) begin
                        // Low pulse shorter than half a bit: treat as a glitch.
                        state_d = StIdle;
                    end else begin
                        baud_d    = '0;
                        bit_idx_d = 3'd0;
                        state_d   = StData;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StData: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d             = '0;
                    shift_d[bit_idx_q] = rs;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (rs) begin
                        // Leave at the stop midpoint so a following start edge is caught.
                        push_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            StWaitIdle: begin
                // Break or stuck-low line: one error, then wait for the line to recover.
                if (rs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
        end
    end

    // FIFO control; shift_q is stable for a full bit after the stop sample, so it is the push data.
    always_comb begin
        pop       = rx_valid & rx_ready;
        full      = (count_q == FIFO_FULL);
        wr_en     = push_q & (~full | pop);
        overrun_d = push_q & full & ~pop;
        rd_ptr_d  = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d   = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and overrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx_valid  = (count_q != '0);
    assign rx_data   = mem_q[rd_ptr_q];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule
